// File: rtl/systolic_pe_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pe_pkg
// Shared accelerator constants for the systolic-array processing element.
//   DATA_W   : default operand width (feature / weight)
//   PSUM_W   : derived partial-sum width (2*DATA_W)
//   PSUM_RST : value every PE register takes on reset (all bits)
// -----------------------------------------------------------------------------
package systolic_pe_pkg;

    localparam int DATA_W = 8;
    localparam int PSUM_W = 2 * DATA_W;

    localparam logic PSUM_RST = 1'b0;

endpackage : systolic_pe_pkg

// File: rtl/systolic_pe_if.sv
// -----------------------------------------------------------------------------
// systolic_pe_if
// Per-PE signal bundle between the array controller / neighbours and one PE.
//   Sclr       : base select, 1 = restart from C, 0 = accumulate onto own P
//   compute_SA : compute enable, 0 = hold
//   F, W       : feature and stationary weight operands (N bits)
//   C          : upstream partial sum (2N bits)
//   Next_F     : registered feature for the right neighbour (N bits)
//   P          : registered partial sum (2N bits)
// Modports: master = array side, slave = the PE.
// -----------------------------------------------------------------------------
interface systolic_pe_if
    import systolic_pe_pkg::*;
#(
    parameter int N = DATA_W
) ();

    logic             Sclr;
    logic             compute_SA;
    logic [N-1:0]     F;
    logic [N-1:0]     W;
    logic [2*N-1:0]   C;
    logic [N-1:0]     Next_F;
    logic [2*N-1:0]   P;

    modport master (
        output Sclr,
        output compute_SA,
        output F,
        output W,
        output C,
        input  Next_F,
        input  P
    );

    modport slave (
        input  Sclr,
        input  compute_SA,
        input  F,
        input  W,
        input  C,
        output Next_F,
        output P
    );

endinterface : systolic_pe_if

// File: rtl/systolic_pe_mac.sv
// -----------------------------------------------------------------------------
// systolic_pe_mac
// Combinational unsigned multiply-add: o_sum = i_base + i_f * i_w, modulo 2^(2N).
// Kept separate so the multiplier can be mapped to a DSP or swapped later.
//   i_f, i_w : N-bit unsigned operands
//   i_base   : 2N-bit accumulation base
//   o_sum    : 2N-bit wrapped result
// -----------------------------------------------------------------------------
module systolic_pe_mac
    import systolic_pe_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic [N-1:0]   i_f,
    input  logic [N-1:0]   i_w,
    input  logic [2*N-1:0] i_base,
    output logic [2*N-1:0] o_sum
);

    localparam int PW = 2 * N;

    logic [PW-1:0] w_prod;

    // Full-width product: an NxN unsigned multiply never exceeds 2N bits.
    assign w_prod = PW'(i_f) * PW'(i_w);
    assign o_sum  = i_base + w_prod;

endmodule : systolic_pe_mac

// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
// One weight-stationary systolic-array processing element. Each enabled cycle
// it registers P <= base + F*W (base = C when Sclr, else own P) and forwards F
// to the right neighbour on Next_F with one cycle of delay.
//   Clk   : system clock, rising edge
//   Rst_n : synchronous active-low reset, priority over everything
//   pe    : systolic_pe_if slave (Sclr, compute_SA, F, W, C -> Next_F, P)
// -----------------------------------------------------------------------------
module systolic_pe
    import systolic_pe_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic        Clk,
    input  logic        Rst_n,
    systolic_pe_if.slave pe
);

    localparam int PW = 2 * N;

    logic [N-1:0]  r_next_f;
    logic [PW-1:0] r_p;
    logic [PW-1:0] w_base;
    logic [PW-1:0] w_sum;

    // Base select is combinational so a Sclr toggle acts on the edge it is sampled.
    assign w_base = pe.Sclr ? pe.C : r_p;

    systolic_pe_mac #(
        .N (N)
    ) u_mac (
        .i_f    (pe.F),
        .i_w    (pe.W),
        .i_base (w_base),
        .o_sum  (w_sum)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_next_f <= {N{PSUM_RST}};
            r_p      <= {PW{PSUM_RST}};
        end else if (pe.compute_SA) begin
            r_next_f <= pe.F;
            r_p      <= w_sum;
        end
    end

    assign pe.Next_F = r_next_f;
    assign pe.P      = r_p;

endmodule : systolic_pe

// File: tb/tb_systolic_pe.sv
// -----------------------------------------------------------------------------
// tb_systolic_pe
// Self-checking bench for systolic_pe. Each driven cycle pushes the expected
// {P, Next_F} onto a scoreboard queue; the entry is popped and compared after
// the edge that should produce it. Test-plan constants are also checked.
// -----------------------------------------------------------------------------
module tb_systolic_pe;

    logic Clk;
    logic Rst_n;

    systolic_pe_if #(.N(8)) u_if ();

    systolic_pe #(.N(8)) u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .pe    (u_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] p;
        logic [7:0]  nf;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_p;
    logic [7:0]  m_nf;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic step(input logic rst_n, input logic en, input logic sclr,
                        input logic [7:0] f, input logic [7:0] w, input logic [15:0] c);
        exp_t e;
        exp_t o;
        @(negedge Clk);
        Rst_n          = rst_n;
        u_if.compute_SA = en;
        u_if.Sclr      = sclr;
        u_if.F         = f;
        u_if.W         = w;
        u_if.C         = c;
        if (!rst_n) begin
            m_p  = 16'h0;
            m_nf = 8'h0;
        end else if (en) begin
            m_p  = (sclr ? c : m_p) + 16'(f) * 16'(w);
            m_nf = f;
        end
        e.p  = m_p;
        e.nf = m_nf;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            chk("sb_P", 32'(u_if.P), 32'(o.p));
            chk("sb_Next_F", 32'(u_if.Next_F), 32'(o.nf));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_p      = 16'h0;
        m_nf     = 8'h0;
        Rst_n          = 1'b0;
        u_if.compute_SA = 1'b1;
        u_if.Sclr      = 1'b1;
        u_if.F         = 8'h55;
        u_if.W         = 8'h03;
        u_if.C         = 16'h0;

        // Reset for 2 cycles
        step(1'b0, 1'b1, 1'b1, 8'h55, 8'h03, 16'h0);
        step(1'b0, 1'b1, 1'b1, 8'h55, 8'h03, 16'h0);
        chk("rst_P", 32'(u_if.P), 32'h0);
        chk("rst_Next_F", 32'(u_if.Next_F), 32'h0);
        step(1'b1, 1'b1, 1'b1, 8'h55, 8'h03, 16'h0);
        chk("post_rst_P", 32'(u_if.P), 32'h00FF);
        chk("post_rst_Next_F", 32'(u_if.Next_F), 32'h55);

        // Pass-through ramp
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'(i), 8'h01, 16'h0);
            chk("ramp_P", 32'(u_if.P), 32'(i));
            chk("ramp_Next_F", 32'(u_if.Next_F), 32'(i));
        end

        // Enable hold with changing inputs
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, (i % 2) == 0, 8'(100 + i), 8'(7 + i), 16'h1234);
            chk("hold_P", 32'(u_if.P), 32'd9);
            chk("hold_Next_F", 32'(u_if.Next_F), 32'd9);
        end
        step(1'b1, 1'b1, 1'b1, 8'd10, 8'h01, 16'h0);
        chk("resume_P", 32'(u_if.P), 32'd10);
        chk("resume_Next_F", 32'(u_if.Next_F), 32'd10);

        // Local accumulation from P=0
        step(1'b1, 1'b1, 1'b1, 8'd0, 8'd2, 16'h0);
        chk("acc_clear", 32'(u_if.P), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'd3, 8'd2, 16'hFFFF);
            chk("acc_P", 32'(u_if.P), 32'(6 * i));
        end
        step(1'b1, 1'b1, 1'b1, 8'd3, 8'd2, 16'd100);
        chk("acc_restart", 32'(u_if.P), 32'd106);

        // Width / wrap
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 16'h0);
        chk("wide_P", 32'(u_if.P), 32'hFE01);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 16'h0);
        chk("wrap_P", 32'(u_if.P), 32'hFC02);

        // Reset mid-run at P=24
        step(1'b1, 1'b1, 1'b1, 8'd0, 8'd2, 16'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'd3, 8'd2, 16'h0);
        chk("pre_midrst_P", 32'(u_if.P), 32'd24);
        step(1'b0, 1'b1, 1'b0, 8'd3, 8'd2, 16'h0);
        chk("midrst_P", 32'(u_if.P), 32'd0);
        chk("midrst_Next_F", 32'(u_if.Next_F), 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'd3, 8'd2, 16'h0);
        chk("after_midrst_P", 32'(u_if.P), 32'd6);

        // Random mix of enable, base select and operands
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 16'($urandom));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_systolic_pe
